// File: rtl/apbspi_spi_slave_if.sv
// ============================================================================
// Module   : apbspi_spi_slave_if
// Brief    : SPI pins plus parallel TX/RX handshake bundle for apbspi_spi_slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apbspi_spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  busy;
    logic                  rx_overrun;
    logic                  tx_underrun;
    logic                  err_clr;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready, err_clr,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy,
               rx_overrun, tx_underrun
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready, err_clr,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, busy,
               rx_overrun, tx_underrun
    );
endinterface

`default_nettype wire

// File: rtl/apbspi_spi_slave.sv
// ============================================================================
// Module   : apbspi_spi_slave
// Brief    : Oversampled mode-0 SPI slave; deserializes MOSI, serializes MISO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apbspi_spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apbspi_spi_slave_if.slave    bus
);
    localparam int                  c_cnt_w    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0]  c_word_end = c_cnt_w'(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0]  c_last_bit = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  r_state_q,       w_state_d;
    logic [SYNC_STAGES-1:0]  r_sclk_sync_q,   w_sclk_sync_d;
    logic [SYNC_STAGES-1:0]  r_cs_sync_q,     w_cs_sync_d;
    logic [SYNC_STAGES-1:0]  r_mosi_sync_q,   w_mosi_sync_d;
    logic                    r_sclk_hist_q,   w_sclk_hist_d;
    logic                    r_cs_hist_q,     w_cs_hist_d;
    logic [c_cnt_w-1:0]      r_bit_cnt_q,     w_bit_cnt_d;
    // Shifters omit the bit already on the wire (TX) / not yet arrived (RX).
    logic [DATA_WIDTH-2:0]   r_tx_rem_q,      w_tx_rem_d;
    logic [DATA_WIDTH-2:0]   r_rx_shift_q,    w_rx_shift_d;
    logic [DATA_WIDTH-1:0]   r_hold_q,        w_hold_d;
    logic                    r_hold_full_q,   w_hold_full_d;
    logic                    r_miso_q,        w_miso_d;
    logic                    r_miso_oe_q,     w_miso_oe_d;
    logic [DATA_WIDTH-1:0]   r_rx_data_q,     w_rx_data_d;
    logic                    r_rx_valid_q,    w_rx_valid_d;
    logic                    r_rx_overrun_q,  w_rx_overrun_d;
    logic                    r_tx_underrun_q, w_tx_underrun_d;

    logic                    w_sclk, w_cs_n, w_mosi;
    logic                    w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic [DATA_WIDTH-1:0]   w_load_word;
    logic                    w_load, w_ovr_set, w_und_set;

    assign w_sclk      = r_sclk_sync_q[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync_q[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_hist_q;
    assign w_sclk_fall = ~w_sclk & r_sclk_hist_q;
    assign w_cs_fall   = ~w_cs_n & r_cs_hist_q;
    assign w_cs_rise   = w_cs_n & ~r_cs_hist_q;
    assign w_load_word = r_hold_full_q ? r_hold_q : '0;

    always_comb begin
        w_state_d       = r_state_q;
        w_sclk_sync_d   = {r_sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
        w_cs_sync_d     = {r_cs_sync_q[SYNC_STAGES-2:0],   bus.spi_cs_n};
        w_mosi_sync_d   = {r_mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        w_sclk_hist_d   = w_sclk;
        w_cs_hist_d     = w_cs_n;
        w_bit_cnt_d     = r_bit_cnt_q;
        w_tx_rem_d      = r_tx_rem_q;
        w_rx_shift_d    = r_rx_shift_q;
        w_hold_d        = r_hold_q;
        w_hold_full_d   = r_hold_full_q;
        w_miso_d        = r_miso_q;
        w_miso_oe_d     = r_miso_oe_q;
        w_rx_data_d     = r_rx_data_q;
        w_rx_valid_d    = r_rx_valid_q;
        w_rx_overrun_d  = r_rx_overrun_q;
        w_tx_underrun_d = r_tx_underrun_q;
        w_load          = 1'b0;
        w_ovr_set       = 1'b0;
        w_und_set       = 1'b0;

        if (r_rx_valid_q && bus.rx_ready) begin
            w_rx_valid_d = 1'b0;
        end

        case (r_state_q)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_d   = ST_SHIFT;
                    w_load      = 1'b1;
                    w_bit_cnt_d = '0;
                    w_miso_oe_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_d   = ST_IDLE;
                    w_bit_cnt_d = '0;
                    w_miso_oe_d = 1'b0;
                    w_miso_d    = 1'b0;
                end else if (w_sclk_rise) begin
                    w_rx_shift_d = {r_rx_shift_q[DATA_WIDTH-3:0], w_mosi};
                    w_bit_cnt_d  = r_bit_cnt_q + c_cnt_one;
                    if (r_bit_cnt_q == c_last_bit) begin
                        if (!r_rx_valid_q || bus.rx_ready) begin
                            w_rx_data_d  = {r_rx_shift_q, w_mosi};
                            w_rx_valid_d = 1'b1;
                        end else begin
                            w_ovr_set = 1'b1;
                        end
                    end
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt_q == c_word_end) begin
                        w_bit_cnt_d = '0;
                        w_load      = 1'b1;
                    end else if (r_bit_cnt_q != '0) begin
                        w_miso_d   = r_tx_rem_q[DATA_WIDTH-2];
                        w_tx_rem_d = {r_tx_rem_q[DATA_WIDTH-3:0], 1'b0};
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_load) begin
            w_tx_rem_d    = w_load_word[DATA_WIDTH-2:0];
            w_miso_d      = w_load_word[DATA_WIDTH-1];
            w_und_set     = ~r_hold_full_q;
            w_hold_full_d = 1'b0;
        end

        if (bus.tx_valid && !r_hold_full_q) begin
            w_hold_d      = bus.tx_data;
            w_hold_full_d = 1'b1;
        end

        // A same-cycle set beats the clear.
        if (bus.err_clr) begin
            w_rx_overrun_d  = 1'b0;
            w_tx_underrun_d = 1'b0;
        end
        if (w_ovr_set) w_rx_overrun_d  = 1'b1;
        if (w_und_set) w_tx_underrun_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state_q       <= ST_IDLE;
            r_sclk_sync_q   <= '0;
            r_cs_sync_q     <= '1;
            r_mosi_sync_q   <= '0;
            r_sclk_hist_q   <= 1'b0;
            r_cs_hist_q     <= 1'b1;
            r_bit_cnt_q     <= '0;
            r_tx_rem_q      <= '0;
            r_rx_shift_q    <= '0;
            r_hold_q        <= '0;
            r_hold_full_q   <= 1'b0;
            r_miso_q        <= 1'b0;
            r_miso_oe_q     <= 1'b0;
            r_rx_data_q     <= '0;
            r_rx_valid_q    <= 1'b0;
            r_rx_overrun_q  <= 1'b0;
            r_tx_underrun_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_sclk_sync_q   <= w_sclk_sync_d;
            r_cs_sync_q     <= w_cs_sync_d;
            r_mosi_sync_q   <= w_mosi_sync_d;
            r_sclk_hist_q   <= w_sclk_hist_d;
            r_cs_hist_q     <= w_cs_hist_d;
            r_bit_cnt_q     <= w_bit_cnt_d;
            r_tx_rem_q      <= w_tx_rem_d;
            r_rx_shift_q    <= w_rx_shift_d;
            r_hold_q        <= w_hold_d;
            r_hold_full_q   <= w_hold_full_d;
            r_miso_q        <= w_miso_d;
            r_miso_oe_q     <= w_miso_oe_d;
            r_rx_data_q     <= w_rx_data_d;
            r_rx_valid_q    <= w_rx_valid_d;
            r_rx_overrun_q  <= w_rx_overrun_d;
            r_tx_underrun_q <= w_tx_underrun_d;
        end
    end

    assign bus.spi_miso    = r_miso_q;
    assign bus.spi_miso_oe = r_miso_oe_q;
    assign bus.tx_ready    = ~r_hold_full_q;
    assign bus.rx_data     = r_rx_data_q;
    assign bus.rx_valid    = r_rx_valid_q;
    assign bus.busy        = (r_state_q == ST_SHIFT);
    assign bus.rx_overrun  = r_rx_overrun_q;
    assign bus.tx_underrun = r_tx_underrun_q;

endmodule

`default_nettype wire

// File: doc/apbspi_spi_slave.md
Name: apbspi_spi_slave

Overview:
Synthesizable SPI slave endpoint that sits directly downstream of apbspi_top's SPI master interface (spi_if). It oversamples SCLK/CS_N/MOSI in the pclk domain and deserializes MOSI into parallel words, while serializing a host-supplied word onto MISO. It replaces the behavioural SPI slave model on the bench and serves as the reusable slave-side peripheral for loopback and SoC-level tests.

Parameters:
DATA_WIDTH, 8, word length in bits, range 4..32; MSB transmitted first.
SYNC_STAGES, 2, synchronizer depth for spi_sclk/spi_cs_n/spi_mosi, range 2..3.

Ports:
pclk  in  1  system clock; all state on rising edge
presetn  in  1  asynchronous active-low reset
spi_sclk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
spi_cs_n  in  1  chip select, active low
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  MISO output enable (high while selected)
tx_data  in  DATA_WIDTH  word to return to master
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  DATA_WIDTH  last received word
rx_valid  out  1  rx_data valid, held until consumed
rx_ready  in  1  consumer accepts rx_data
busy  out  1  transfer in progress (state SHIFT)
rx_overrun  out  1  sticky: word completed while rx_valid still high
tx_underrun  out  1  sticky: word load with TX holding register empty
err_clr  in  1  single-cycle pulse clears both sticky flags

Behaviour:
- Reset (presetn low, async): spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, rx_overrun=0, tx_underrun=0; synchronizer flops reset to sclk=0, cs_n=1, mosi=0; state IDLE.
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detect on sclk and cs_n. Supported SCLK ≤ pclk/8.
- TX holding register: accepted when tx_valid && tx_ready; tx_ready drops the next cycle. Emptied when loaded into the TX shifter; tx_ready returns high the following cycle.
- FSM IDLE: on synced cs_n falling edge -> SHIFT; load TX shifter from holding register (or all-zeros and set tx_underrun if empty); bit_cnt=0; spi_miso=shifter MSB; spi_miso_oe=1.
- SHIFT, synced sclk rising edge: shift synced mosi into RX shifter LSB; bit_cnt++.
- SHIFT, synced sclk falling edge: if bit_cnt != 0, shift TX left, spi_miso=next bit. If bit_cnt == DATA_WIDTH (word boundary): bit_cnt=0, reload TX shifter per IDLE load rule (continuous multi-word transfers under one CS).
- Word completion: on the rising edge producing bit_cnt==DATA_WIDTH, next cycle: if rx_valid==0 or rx_ready==1 that cycle, rx_data=RX shifter, rx_valid=1; otherwise set rx_overrun, drop the new word, keep old rx_data.
- rx_valid clears on a cycle with rx_ready high and no simultaneous completion; simultaneous consume+complete leaves rx_valid=1 with new data.
- Latency: rx_valid rises SYNC_STAGES+1 pclk cycles after the raw final sclk rising edge.
- cs_n rising edge (synced) in SHIFT: -> IDLE next cycle; partial word discarded (no rx_valid, no overrun); a word already loaded into TX shifter is lost (not returned to holding reg); spi_miso_oe=0, spi_miso=0, busy=0.
- err_clr has priority below a same-cycle set (set wins).
- sclk edges while cs_n high are ignored.
- Reset mid-transfer: immediate return to reset values; no partial rx output.

Test Plan:
- Reset: presetn low mid-word (4 of 8 bits shifted) -> all outputs at reset values, rx_valid stays 0 after release and cs_n toggle.
- Single word: tx_data=8'hA5 preloaded, master sends 8'h3C at pclk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C, rx_valid high SYNC_STAGES+1 cycles after 8th rising edge; tx_ready=1 after load.
- Back-to-back: 3 words 8'h01,8'h02,8'h03 under one CS, tx refilled each word with 8'hF0,8'h0F,8'hFF, rx_ready held 1 -> three rx_valid pulses in order, MISO matches, no sticky flags.
- Overrun: rx_ready=0, two words 8'h11,8'h22 -> rx_data=8'h11, rx_overrun=1; err_clr pulse -> rx_overrun=0.
- Underrun: no tx write, master clocks one word -> MISO all 0, tx_underrun=1.
- Abort: cs_n deasserted after 5 bits -> busy=0 next synced cycle, no rx_valid, miso_oe=0; next full word 8'h5A received correctly.
